// File: rtl/countdown_sec_min.sv
// Minutes:seconds countdown timer with borrow, done pulse and timed alarm.
// Latency: every output is registered and changes on the edge that samples its trigger.
// Backpressure: none; setting pulses are honoured only in IDLE, and ticks only in RUN/ALARM.
module countdown_sec_min #(
  parameter int SEC_MAX     = 59,
  parameter int MIN_MAX     = 59,
  parameter int ALARM_TICKS = 8
) (
  input  logic       clock,
  input  logic       reset_sec,
  input  logic       enable_sec,
  input  logic       load_sec,
  input  logic       setting_sec,
  input  logic       setting_min,
  input  logic       start_stop,
  output logic [5:0] count_sec,
  output logic [5:0] count_min,
  output logic       borrow_sec,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int AW = $clog2(ALARM_TICKS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] ALARM = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [5:0]    sec_nxt, min_nxt;
  logic [AW-1:0] alarm_cnt, alarm_cnt_nxt;
  logic          borrow_nxt, done_nxt;
  logic          count_zero;

  assign count_zero = (count_sec == 6'd0) && (count_min == 6'd0);

  // Next-state and next-count decision for the whole timer.
  always_comb begin
    state_nxt     = state;
    sec_nxt       = count_sec;
    min_nxt       = count_min;
    alarm_cnt_nxt = alarm_cnt;
    borrow_nxt    = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (load_sec) begin
          // Setting wraps each field on its own; no borrow or carry between them.
          if (setting_sec)
            sec_nxt = (count_sec >= 6'(SEC_MAX)) ? 6'd0 : count_sec + 6'd1;
          if (setting_min)
            min_nxt = (count_min >= 6'(MIN_MAX)) ? 6'd0 : count_min + 6'd1;
        end else if (start_stop && !count_zero) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (enable_sec) begin
          if (count_sec != 6'd0) begin
            sec_nxt = count_sec - 6'd1;
          end else if (count_min != 6'd0) begin
            sec_nxt    = 6'(SEC_MAX);
            min_nxt    = count_min - 6'd1;
            borrow_nxt = 1'b1;
          end
        end
        // Reaching 00:00 outranks a simultaneous pause request.
        if (enable_sec && (sec_nxt == 6'd0) && (min_nxt == 6'd0)) begin
          state_nxt     = ALARM;
          done_nxt      = 1'b1;
          alarm_cnt_nxt = '0;
        end else if (start_stop) begin
          state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        // Editing request beats resume so the user can always get to IDLE.
        if (load_sec)
          state_nxt = IDLE;
        else if (start_stop)
          state_nxt = RUN;
      end
      ALARM: begin
        if (start_stop) begin
          state_nxt     = IDLE;
          alarm_cnt_nxt = '0;
        end else if (enable_sec) begin
          if (alarm_cnt == AW'(ALARM_TICKS - 1)) begin
            state_nxt     = IDLE;
            alarm_cnt_nxt = '0;
          end else begin
            alarm_cnt_nxt = alarm_cnt + AW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Register state, counts and all status outputs.
  always_ff @(posedge clock or posedge reset_sec) begin
    if (reset_sec) begin
      state      <= IDLE;
      count_sec  <= 6'd0;
      count_min  <= 6'd0;
      alarm_cnt  <= '0;
      borrow_sec <= 1'b0;
      done       <= 1'b0;
      running    <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state      <= state_nxt;
      count_sec  <= sec_nxt;
      count_min  <= min_nxt;
      alarm_cnt  <= alarm_cnt_nxt;
      borrow_sec <= borrow_nxt;
      done       <= done_nxt;
      running    <= (state_nxt == RUN);
      alarm      <= (state_nxt == ALARM);
    end
  end

endmodule
